// File: rtl/conv2d_stream_mc_if.sv
// Handshake bundle for the multi-channel streaming convolution block.
// Carries the weight load port, the activation stream and the result stream.
interface conv2d_stream_mc_if #(
    parameter int WIDTH = 16,
    parameter int C     = 2
);
    logic                 wt_valid;
    logic [WIDTH-1:0]     wt_in;
    logic                 wt_ready;
    logic                 act_valid;
    logic [C*WIDTH-1:0]   activation;
    logic                 act_ready;
    logic [WIDTH-1:0]     conv_out;
    logic                 conv_valid;
    logic                 conv_last;
    logic                 busy;

    modport master (
        output wt_valid, wt_in, act_valid, activation,
        input  wt_ready, act_ready, conv_out, conv_valid, conv_last, busy
    );

    modport slave (
        input  wt_valid, wt_in, act_valid, activation,
        output wt_ready, act_ready, conv_out, conv_valid, conv_last, busy
    );
endinterface

// File: rtl/conv2d_stream_mc.sv
// Streaming KxK convolution over C parallel input channels producing one
// output channel: serial weight load, per-channel line windows, 2-stage MAC.
module conv2d_stream_mc #(
    parameter int N     = 10,
    parameter int K     = 3,
    parameter int S     = 1,
    parameter int C     = 2,
    parameter int WIDTH = 16,
    parameter int Q     = 12
) (
    input  logic              clk,
    input  logic              glb_rst,
    input  logic              clk_en,
    conv2d_stream_mc_if.slave s_if
);
    localparam int KK = K * K;
    localparam int NW = C * KK;
    localparam int D  = (K - 1) * N + K;
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + $clog2(NW);
    localparam int CW = $clog2(N);
    localparam int WC = $clog2(NW);
    localparam logic [CW-1:0] KM1   = CW'(K - 1);
    localparam logic [CW-1:0] NM1   = CW'(N - 1);
    localparam logic [CW-1:0] SS    = CW'(S);
    localparam logic [WC-1:0] WLAST = WC'(NW - 1);
    localparam logic signed [AW-1:0] RND  = AW'(1) << (Q - 1);
    localparam logic signed [AW-1:0] SMAX =
        AW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = -SMAX - AW'(1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    state_t r_state, w_state_nx;

    logic signed [WIDTH-1:0] r_wt     [NW];
    logic signed [WIDTH-1:0] r_win    [C][D];
    logic signed [WIDTH-1:0] w_win_nx [C][D];
    logic signed [PW-1:0]    r_prod   [NW];
    logic signed [PW-1:0]    w_prod   [NW];
    logic [WC-1:0]           r_wcnt;
    logic [CW-1:0]           r_row, r_col;
    logic                    r_v1, r_l1, r_v2, r_l2;
    logic signed [WIDTH-1:0] r_out;
    logic                    w_wt_ready, w_act_ready;
    logic                    w_wt_fire, w_px_fire, w_qual, w_frame_end;
    logic signed [AW-1:0]    w_sum, w_rnd;
    logic signed [WIDTH-1:0] w_sat;

    assign w_wt_ready  = (r_state == IDLE) || (r_state == LOAD);
    assign w_act_ready = (r_state == RUN);
    assign w_wt_fire   = clk_en & s_if.wt_valid & w_wt_ready;
    assign w_px_fire   = clk_en & s_if.act_valid & w_act_ready;
    assign w_frame_end = (r_row == NM1) && (r_col == NM1);
    assign w_qual = (r_row >= KM1) && (r_col >= KM1) &&
                    (((r_row - KM1) % SS) == '0) &&
                    (((r_col - KM1) % SS) == '0);

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            IDLE:  if (w_wt_fire) w_state_nx = LOAD;
            LOAD:  if (w_wt_fire && r_wcnt == WLAST) w_state_nx = RUN;
            RUN:   if (w_px_fire && w_frame_end) w_state_nx = DRAIN;
            DRAIN: if (!r_v1 && !r_v2) w_state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge glb_rst) begin
        if (!glb_rst) r_state <= IDLE;
        else if (clk_en) r_state <= w_state_nx;
    end

    // Window view including the pixel being accepted this cycle.
    always_comb begin
        for (int ch = 0; ch < C; ch++) begin
            w_win_nx[ch][0] = s_if.activation[ch*WIDTH +: WIDTH];
            for (int i = 1; i < D; i++) w_win_nx[ch][i] = r_win[ch][i-1];
        end
    end

    always_comb begin
        for (int ch = 0; ch < C; ch++)
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    w_prod[ch*KK + kr*K + kc] =
                        PW'(w_win_nx[ch][(K-1-kr)*N + (K-1-kc)]) *
                        PW'(r_wt[ch*KK + kr*K + kc]);
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NW; i++) w_sum = w_sum + AW'(r_prod[i]);
        w_rnd = (w_sum + RND) >>> Q;
        if (w_rnd > SMAX)      w_sat = SMAX[WIDTH-1:0];
        else if (w_rnd < SMIN) w_sat = SMIN[WIDTH-1:0];
        else                   w_sat = w_rnd[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge glb_rst) begin
        if (!glb_rst) begin
            r_wcnt <= '0;
            r_row  <= '0;
            r_col  <= '0;
            r_v1   <= 1'b0;
            r_l1   <= 1'b0;
            r_v2   <= 1'b0;
            r_l2   <= 1'b0;
            r_out  <= '0;
            for (int i = 0; i < NW; i++) begin
                r_wt[i]   <= '0;
                r_prod[i] <= '0;
            end
            for (int ch = 0; ch < C; ch++)
                for (int i = 0; i < D; i++) r_win[ch][i] <= '0;
        end else if (clk_en) begin
            if (w_wt_fire) begin
                r_wt[r_wcnt] <= s_if.wt_in;
                r_wcnt <= (r_wcnt == WLAST) ? '0 : r_wcnt + 1'b1;
            end
            if (w_px_fire) begin
                r_win <= w_win_nx;
                if (r_col == NM1) begin
                    r_col <= '0;
                    r_row <= (r_row == NM1) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_v1 <= w_px_fire & w_qual;
            r_l1 <= w_px_fire & w_qual & w_frame_end;
            if (w_px_fire & w_qual) r_prod <= w_prod;
            r_v2 <= r_v1;
            r_l2 <= r_l1;
            if (r_v1) r_out <= w_sat;
        end
    end

    assign s_if.wt_ready   = w_wt_ready;
    assign s_if.act_ready  = w_act_ready;
    assign s_if.conv_out   = r_out;
    assign s_if.conv_valid = r_v2;
    assign s_if.conv_last  = r_l2;
    assign s_if.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_conv2d_stream_mc.sv
// Randomised bench for conv2d_stream_mc: frame-level reference model,
// per-output compare of value, last flag and latency, plus literal pins.
module tb_conv2d_stream_mc;
    localparam int N = 5, K = 3, S = 2, C = 2, WIDTH = 16, Q = 12;
    localparam int O  = (N - K) / S + 1;
    localparam int NW = C * K * K;

    logic clk = 1'b0;
    logic glb_rst;
    logic clk_en;

    conv2d_stream_mc_if #(.WIDTH(WIDTH), .C(C)) ifc ();

    conv2d_stream_mc #(
        .N(N), .K(K), .S(S), .C(C), .WIDTH(WIDTH), .Q(Q)
    ) dut (
        .clk(clk),
        .glb_rst(glb_rst),
        .clk_en(clk_en),
        .s_if(ifc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int en_cyc = 0;
    int n_valid = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             last_q[$];
    int               stamp_q[$];
    logic [WIDTH-1:0] lit_q[$];
    logic signed [WIDTH-1:0] wts[C][K][K];
    logic signed [WIDTH-1:0] pix[C][N][N];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (clk_en) en_cyc++;
    end

    initial begin : mon
        int last_chk;
        int s;
        logic [WIDTH-1:0] v;
        logic l;
        last_chk = -1;
        forever begin
            @(negedge clk);
            if (glb_rst && ifc.conv_valid && en_cyc != last_chk) begin
                last_chk = en_cyc;
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    v = exp_q.pop_front();
                    l = last_q.pop_front();
                    chk("conv_out", int'(ifc.conv_out), int'(v));
                    chk("conv_last", int'(ifc.conv_last), int'(l));
                    if (stamp_q.size() == 0) chk("latency_stamp", 0, 1);
                    else begin
                        s = stamp_q.pop_front();
                        chk("latency", en_cyc, s + 2);
                    end
                    if (lit_q.size() != 0)
                        chk("literal", int'(ifc.conv_out),
                            int'(lit_q.pop_front()));
                end
            end
        end
    end

    task automatic build_expected();
        longint acc, r;
        for (int orow = 0; orow < O; orow++)
            for (int ocol = 0; ocol < O; ocol++) begin
                acc = 0;
                for (int ch = 0; ch < C; ch++)
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            acc += longint'(pix[ch][orow*S+kr][ocol*S+kc]) *
                                   longint'(wts[ch][kr][kc]);
                r = (acc + (longint'(1) << (Q - 1))) >>> Q;
                if (r > 32767) r = 32767;
                if (r < -32768) r = -32768;
                exp_q.push_back(WIDTH'(r));
                last_q.push_back(orow == O - 1 && ocol == O - 1);
            end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        glb_rst = 1'b0;
        exp_q.delete(); last_q.delete(); stamp_q.delete(); lit_q.delete();
        repeat (2) @(negedge clk);
        glb_rst = 1'b1;
    endtask

    task automatic load_weights(input bit stall);
        int idx, guard, ch, kr, kc;
        idx = 0;
        guard = 0;
        while (idx < NW && guard < 2000) begin
            @(negedge clk);
            guard++;
            clk_en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            ifc.wt_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            ch = idx / (K * K);
            kr = (idx / K) % K;
            kc = idx % K;
            ifc.wt_in = wts[ch][kr][kc];
            if (clk_en && ifc.wt_valid && ifc.wt_ready) idx++;
        end
        @(negedge clk);
        ifc.wt_valid = 1'b0;
        clk_en = 1'b1;
        chk("load_count", idx, NW);
        chk("wt_ready_run", int'(ifc.wt_ready), 0);
        chk("act_ready_run", int'(ifc.act_ready), 1);
        chk("busy_run", int'(ifc.busy), 1);
    endtask

    task automatic run_frame(input bit stall, input int stop_after);
        int p, guard, r, c;
        p = 0;
        guard = 0;
        build_expected();
        while (p < N * N && p != stop_after && guard < 5000) begin
            @(negedge clk);
            guard++;
            clk_en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            ifc.act_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            ifc.wt_valid = 1'($urandom_range(0, 1));
            ifc.wt_in = WIDTH'($urandom);
            r = p / N;
            c = p % N;
            for (int ch = 0; ch < C; ch++)
                ifc.activation[ch*WIDTH +: WIDTH] = pix[ch][r][c];
            if (clk_en && ifc.act_valid && ifc.act_ready) begin
                if (r >= K - 1 && c >= K - 1 &&
                    (r - K + 1) % S == 0 && (c - K + 1) % S == 0)
                    stamp_q.push_back(en_cyc);
                p++;
            end
        end
        if (guard >= 5000) chk("frame_timeout", p, N * N);
        if (stop_after < 0) begin
            @(negedge clk);
            ifc.act_valid = 1'b0;
            ifc.wt_valid = 1'b0;
            guard = 0;
            while ((exp_q.size() != 0 || !ifc.act_ready) && guard < 400) begin
                clk_en = stall ? ($urandom_range(0, 1) != 0) : 1'b1;
                @(negedge clk);
                guard++;
            end
            clk_en = 1'b1;
            chk("drain_outputs", exp_q.size(), 0);
            chk("rearm_run", int'(ifc.act_ready), 1);
        end
    endtask

    task automatic fill(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                        input logic [WIDTH-1:0] px, input logic [WIDTH-1:0] lit);
        for (int kr = 0; kr < K; kr++)
            for (int kc = 0; kc < K; kc++) begin
                wts[0][kr][kc] = w0;
                wts[1][kr][kc] = w1;
            end
        for (int ch = 0; ch < C; ch++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) pix[ch][r][c] = px;
        repeat (O * O) lit_q.push_back(lit);
    endtask

    initial begin
        int snap;
        logic [WIDTH-1:0] v;
        glb_rst = 1'b0;
        clk_en = 1'b0;
        ifc.wt_valid = 1'b0;
        ifc.wt_in = '0;
        ifc.act_valid = 1'b0;
        ifc.activation = '0;
        #12;
        chk("rst_wt_ready", int'(ifc.wt_ready), 1);
        chk("rst_act_ready", int'(ifc.act_ready), 0);
        chk("rst_conv_out", int'(ifc.conv_out), 0);
        chk("rst_conv_valid", int'(ifc.conv_valid), 0);
        chk("rst_conv_last", int'(ifc.conv_last), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        @(negedge clk);
        glb_rst = 1'b1;
        clk_en = 1'b1;
        ifc.act_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(ifc.busy), 0);
        chk("idle_act_ready", int'(ifc.act_ready), 0);
        ifc.act_valid = 1'b0;

        // 0.25 * 0.5 over 18 taps -> 2.25
        fill(16'h0400, 16'h0400, 16'h0800, 16'h2400);
        load_weights(0);
        run_frame(0, -1);

        reset_dut();
        fill(16'h1000, 16'h1000, 16'h1000, 16'h7FFF);
        load_weights(0);
        run_frame(0, -1);
        fill(16'h1000, 16'h1000, 16'hF000, 16'h8000);
        run_frame(0, -1);

        reset_dut();
        fill(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        lit_q.delete();
        wts[0][1][1] = 16'h1000;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                pix[0][r][c] = WIDTH'(16 * (5 * r + c));
                pix[1][r][c] = WIDTH'($urandom);
            end
        lit_q.push_back(16'd96);
        lit_q.push_back(16'd128);
        lit_q.push_back(16'd256);
        lit_q.push_back(16'd288);
        load_weights(1);
        run_frame(0, -1);

        reset_dut();
        fill(16'h1000, 16'hF000, 16'h0000, 16'h0000);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                v = WIDTH'($urandom);
                pix[0][r][c] = v;
                pix[1][r][c] = v;
            end
        load_weights(1);
        run_frame(1, -1);

        reset_dut();
        fill(16'h0400, 16'h0400, 16'h0800, 16'h2400);
        load_weights(1);
        run_frame(1, -1);
        repeat (O * O) lit_q.push_back(16'h2400);
        run_frame(1, -1);

        reset_dut();
        for (int ch = 0; ch < C; ch++)
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++)
                    wts[ch][kr][kc] = WIDTH'(int'($urandom_range(0, 4095)) - 2048);
        load_weights(1);
        for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < C; ch++)
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) pix[ch][r][c] = WIDTH'($urandom);
            run_frame(1, -1);
        end

        run_frame(0, 7);
        @(negedge clk);
        #2 glb_rst = 1'b0;
        #1;
        chk("midrst_conv_out", int'(ifc.conv_out), 0);
        chk("midrst_busy", int'(ifc.busy), 0);
        chk("midrst_wt_ready", int'(ifc.wt_ready), 1);
        chk("midrst_act_ready", int'(ifc.act_ready), 0);
        chk("midrst_conv_valid", int'(ifc.conv_valid), 0);
        exp_q.delete(); last_q.delete(); stamp_q.delete(); lit_q.delete();
        @(negedge clk);
        glb_rst = 1'b1;
        snap = n_valid;
        ifc.act_valid = 1'b1;
        clk_en = 1'b1;
        repeat (30) @(negedge clk);
        ifc.act_valid = 1'b0;
        chk("no_valid_after_reset", n_valid - snap, 0);
        chk("still_idle", int'(ifc.busy), 0);

        fill(16'h0400, 16'h0400, 16'h0800, 16'h2400);
        load_weights(0);
        run_frame(0, -1);
        chk("literals_consumed", lit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
